// File: rtl/seg7_char_rx_if.sv
// seg7_char_rx_if: character output handshake between the 7-segment receiver and its consumer.
interface seg7_char_rx_if;
    logic       CHAR_VALID;
    logic [2:0] CHAR_CODE;
    logic       CHAR_ERR;
    logic       OUT_READY;
    modport master (output CHAR_VALID, CHAR_CODE, CHAR_ERR, input OUT_READY);
    modport slave  (input CHAR_VALID, CHAR_CODE, CHAR_ERR, output OUT_READY);
endinterface

// File: rtl/seg7_char_rx.sv
// seg7_char_rx: debounces an asynchronous active-low 7-segment pattern and decodes it to a character.
// Define HELLO_DETECT_EN to add the H-E-L-L-O sequence detector and its HELLO_DET port.
module seg7_char_rx #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [6:0]        HEX_IN,
    seg7_char_rx_if.master    char_if,
    output logic              OVERFLOW
`ifdef HELLO_DETECT_EN
    ,
    output logic              HELLO_DET
`endif
);
    localparam logic [3:0] N = 4'(STABLE_CYCLES);

    logic [6:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [2:0] fill_q, fill_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;
    logic [2:0] code_q, code_d, dec_code;
    logic       accept, load;

    // fill forces the pattern present after reset to be treated as a fresh change
    always_comb begin
        s1_d     = HEX_IN;
        s2_d     = s1_q;
        prev_d   = s2_q;
        fill_d   = {fill_q[1:0], 1'b1};
        cnt_d    = (s2_q != prev_q || !fill_q[2]) ? 4'd0 : (cnt_q == N) ? cnt_q : cnt_q + 4'd1;
        accept   = (cnt_d == N) && (cnt_q != N);
        dec_code = (s2_q == 7'h09) ? 3'b000 :
                   (s2_q == 7'h06) ? 3'b001 :
                   (s2_q == 7'h47) ? 3'b010 :
                   (s2_q == 7'h40) ? 3'b011 :
                   (s2_q == 7'h7F) ? 3'b100 : 3'b111;
        load     = accept && (!valid_q || char_if.OUT_READY);
        valid_d  = load || (valid_q && !char_if.OUT_READY);
        code_d   = load ? dec_code : code_q;
        err_d    = load ? (dec_code == 3'b111) : err_q;
        ovf_d    = ovf_q || (accept && valid_q && !char_if.OUT_READY);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign char_if.CHAR_VALID = valid_q;
    assign char_if.CHAR_CODE  = code_q;
    assign char_if.CHAR_ERR   = err_q;
    assign OVERFLOW           = ovf_q;

`ifdef HELLO_DETECT_EN
    typedef enum logic [2:0] {IDLE, GOT_H, GOT_E, GOT_L1, GOT_L2} state_t;
    state_t st_q, st_d;
    logic   hello_q, hello_d;

    // advances on every accept, including characters dropped by the output register
    always_comb begin
        st_d    = st_q;
        hello_d = 1'b0;
        if (accept) begin
            st_d    = (dec_code == 3'b000)                      ? GOT_H  :
                      (dec_code == 3'b100)                      ? st_q   :
                      (st_q == GOT_H  && dec_code == 3'b001)    ? GOT_E  :
                      (st_q == GOT_E  && dec_code == 3'b010)    ? GOT_L1 :
                      (st_q == GOT_L1 && dec_code == 3'b010)    ? GOT_L2 : IDLE;
            hello_d = (st_q == GOT_L2) && (dec_code == 3'b011);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q    <= IDLE;
            hello_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            hello_q <= hello_d;
        end
    end

    assign HELLO_DET = hello_q;
`endif
endmodule

// File: tb/tb_seg7_char_rx.sv
// tb_seg7_char_rx: scoreboard bench for seg7_char_rx; handshakes are popped against queued expectations.
module tb_seg7_char_rx;
    localparam int SC = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [6:0] HEX_IN   = 7'h7F;
    logic       OVERFLOW;
`ifdef HELLO_DETECT_EN
    logic       HELLO_DET;
`endif

    seg7_char_rx_if bus ();

    seg7_char_rx #(.STABLE_CYCLES(SC)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .HEX_IN   (HEX_IN),
        .char_if  (bus),
        .OVERFLOW (OVERFLOW)
`ifdef HELLO_DETECT_EN
        ,
        .HELLO_DET(HELLO_DET)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_hs     = 0;
    int         n_hello  = 0;
    logic [3:0] sb[$];

    function automatic logic [3:0] exp_of(input logic [6:0] v);
        case (v)
            7'h09:   return 4'b0_000;
            7'h06:   return 4'b0_001;
            7'h47:   return 4'b0_010;
            7'h40:   return 4'b0_011;
            7'h7F:   return 4'b0_100;
            default: return 4'b1_111;
        endcase
    endfunction

    always @(negedge CLOCK_50) begin
        if (RESET_N && bus.CHAR_VALID && bus.OUT_READY) begin
            logic [3:0] e;
            n_hs++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL char_unexpected: got err=%0b code=%03b, required no character", bus.CHAR_ERR, bus.CHAR_CODE);
            end else begin
                e = sb.pop_front();
                if ({bus.CHAR_ERR, bus.CHAR_CODE} !== e) begin
                    n_fail++;
                    $display("FAIL char: got err=%0b code=%03b, required err=%0b code=%03b", bus.CHAR_ERR, bus.CHAR_CODE, e[3], e[2:0]);
                end
            end
        end
`ifdef HELLO_DETECT_EN
        if (HELLO_DET === 1'b1) n_hello++;
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic measure(input string name, input int want);
        int e = 0;
        while (bus.CHAR_VALID !== 1'b1 && e < 20) begin
            tick(1);
            e++;
        end
        n_checks++;
        if (e !== want) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, e, want);
        end
    endtask

    task automatic glyph(input logic [6:0] v);
        HEX_IN = 7'h00;
        tick(1);
        HEX_IN = v;
        sb.push_back(exp_of(v));
        tick(SC + 6);
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({bus.CHAR_VALID, bus.CHAR_CODE, bus.CHAR_ERR, OVERFLOW} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b code=%03b err=%0b ovf=%0b, required all 0", name, bus.CHAR_VALID, bus.CHAR_CODE, bus.CHAR_ERR, OVERFLOW);
        end
`ifdef HELLO_DETECT_EN
        n_checks++;
        if (HELLO_DET !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hello: got %0b, required 0", name, HELLO_DET);
        end
`endif
    endtask

    task automatic test_reset();
        bus.OUT_READY = 1'b1;
        HEX_IN = 7'h7F;
        #25;
        check_reset_outputs("reset_state");
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        sb.push_back(4'b0_100);
        measure("reset_release", SC + 3);
        tick(1);
        n_checks++;
        if (bus.CHAR_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_pulse: got valid=%0b, required 0", bus.CHAR_VALID);
        end
    endtask

    task automatic test_latency();
        HEX_IN = 7'h06;
        sb.push_back(4'b0_001);
        measure("latency_E", SC + 3);
        n_checks++;
        if ({bus.CHAR_ERR, bus.CHAR_CODE} !== 4'b0_001) begin
            n_fail++;
            $display("FAIL latency_E code: got err=%0b code=%03b, required err=0 code=001", bus.CHAR_ERR, bus.CHAR_CODE);
        end
        tick(1);
        n_checks++;
        if (bus.CHAR_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_E pulse: got valid=%0b, required 0", bus.CHAR_VALID);
        end
    endtask

    task automatic test_glitch();
        int hs0 = n_hs;
        sb.push_back(4'b0_010);
        for (int i = 0; i < 10; i++) begin
            HEX_IN = (i % 2 == 1) ? 7'h47 : 7'h09;
            tick(2);
        end
        tick(SC + 8);
        n_checks++;
        if (n_hs - hs0 !== 1) begin
            n_fail++;
            $display("FAIL glitch accepts: got %0d, required 1", n_hs - hs0);
        end
        n_checks++;
        if (bus.CHAR_CODE !== 3'b010) begin
            n_fail++;
            $display("FAIL glitch code: got %03b, required 010", bus.CHAR_CODE);
        end
    endtask

    task automatic test_error();
        HEX_IN = 7'h55;
        sb.push_back(4'b1_111);
        tick(SC + 8);
        n_checks++;
        if ({bus.CHAR_ERR, bus.CHAR_CODE} !== 4'b1_111) begin
            n_fail++;
            $display("FAIL error_glyph: got err=%0b code=%03b, required err=1 code=111", bus.CHAR_ERR, bus.CHAR_CODE);
        end
    endtask

    task automatic test_overflow();
        bus.OUT_READY = 1'b0;
        HEX_IN = 7'h09;
        tick(SC + 6);
        n_checks++;
        if ({bus.CHAR_VALID, bus.CHAR_CODE, OVERFLOW} !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL ovf_hold_H: got valid=%0b code=%03b ovf=%0b, required valid=1 code=000 ovf=0", bus.CHAR_VALID, bus.CHAR_CODE, OVERFLOW);
        end
        HEX_IN = 7'h40;
        for (int i = 0; i < SC + 6; i++) begin
            tick(1);
            n_checks++;
            if ({bus.CHAR_VALID, bus.CHAR_CODE} !== 4'b1_000) begin
                n_fail++;
                $display("FAIL ovf_stall cycle %0d: got valid=%0b code=%03b, required valid=1 code=000", i, bus.CHAR_VALID, bus.CHAR_CODE);
            end
        end
        n_checks++;
        if (OVERFLOW !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %0b, required 1", OVERFLOW);
        end
        sb.push_back(4'b0_000);
        bus.OUT_READY = 1'b1;
        tick(1);
        n_checks++;
        if ({bus.CHAR_VALID, OVERFLOW} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_drain: got valid=%0b ovf=%0b, required valid=0 ovf=1", bus.CHAR_VALID, OVERFLOW);
        end
    endtask

    task automatic test_hello();
`ifdef HELLO_DETECT_EN
        int h0 = n_hello;
        glyph(7'h09); glyph(7'h06); glyph(7'h7F); glyph(7'h47); glyph(7'h47); glyph(7'h40);
        n_checks++;
        if (n_hello - h0 !== 1) begin
            n_fail++;
            $display("FAIL hello_seq: got %0d pulse cycles, required 1", n_hello - h0);
        end
        h0 = n_hello;
        glyph(7'h09); glyph(7'h06); glyph(7'h47); glyph(7'h47); glyph(7'h47); glyph(7'h40);
        n_checks++;
        if (n_hello - h0 !== 0) begin
            n_fail++;
            $display("FAIL hello_extra_L: got %0d pulse cycles, required 0", n_hello - h0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        glyph(7'h7F);
        HEX_IN = 7'h40;
        tick(2);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        sb.push_back(4'b0_011);
        measure("reset_mid_O", SC + 3);
        n_checks++;
        if (bus.CHAR_CODE !== 3'b011) begin
            n_fail++;
            $display("FAIL reset_mid code: got %03b, required 011", bus.CHAR_CODE);
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_error();
        test_overflow();
        test_hello();
        test_reset_mid();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_char_rx.md
SEG7_CHAR_RX -- requirements
Module: seg7_char_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive stable sampled cycles before a pattern is accepted (legal range 1..15).
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 HEX_IN  input  7  active-low 7-segment pattern, bit0 = segment a through bit6 = segment g; asynchronous to CLOCK_50.
REQ-005 OUT_READY  input  1  downstream accepts CHAR_CODE when high with CHAR_VALID.
REQ-006 CHAR_VALID  output  1  CHAR_CODE/CHAR_ERR hold a decoded character.
REQ-007 CHAR_CODE  output  3  decoded character code.
REQ-008 CHAR_ERR  output  1  accepted pattern was not a legal glyph.
REQ-009 OVERFLOW  output  1  sticky: an accepted character was dropped.
REQ-010 HELLO_DET  output  1  one-cycle pulse on completed H-E-L-L-O sequence (present only with HELLO_DETECT_EN).

Function
REQ-011 HEX_IN shall pass through a two-flop synchronizer; all later logic uses the second stage (S2).
REQ-012 A stability counter shall clear to 0 whenever S2 differs from its previous-cycle value, else increment, saturating at STABLE_CYCLES.
REQ-013 An accept event shall occur in the single cycle the counter first reaches STABLE_CYCLES; no further accept until S2 changes and restabilizes.
REQ-014 Decode table (HEX_IN hex -> CHAR_CODE): 0x09 H -> 000; 0x06 E -> 001; 0x47 L -> 010; 0x40 O -> 011; 0x7F blank -> 100; any other value -> 111 with CHAR_ERR=1.
REQ-015 Latency: with HEX_IN stable, CHAR_VALID shall rise on the (STABLE_CYCLES+3)th rising edge after HEX_IN changes.
REQ-016 Output register: on accept with CHAR_VALID=0, or CHAR_VALID=1 and OUT_READY=1, load CHAR_CODE/CHAR_ERR and set CHAR_VALID=1.
REQ-017 CHAR_VALID=1 and OUT_READY=1 with no accept: clear CHAR_VALID next edge.
REQ-018 Accept while CHAR_VALID=1 and OUT_READY=0: keep held character unchanged, drop new one, set OVERFLOW=1.
REQ-019 OVERFLOW shall clear only on reset.
REQ-020 CHAR_CODE/CHAR_ERR shall not change while CHAR_VALID=1 and OUT_READY=0.
REQ-021 Sequence FSM states IDLE, GOT_H, GOT_E, GOT_L1, GOT_L2; advances on accept events, not on handshakes, including dropped characters.
REQ-022 Transitions: expected next glyph advances state; blank holds state; error code returns to IDLE; H in any state goes to GOT_H; any other mismatch goes to IDLE.
REQ-023 O in GOT_L2 shall pulse HELLO_DET for one cycle, registered with the accept, and return to IDLE.

Reset
REQ-024 RESET_N low shall immediately clear synchronizer, counter, CHAR_VALID, CHAR_CODE (000), CHAR_ERR, OVERFLOW, HELLO_DET and set FSM to IDLE.
REQ-025 Reset mid-stabilization shall discard the pending pattern; after release the current HEX_IN is treated as new and is accepted after full latency.
REQ-026 Reset release shall be taken synchronously by all state on the next rising edge.

Configuration
REQ-027 Macro HELLO_DETECT_EN defined: sequence FSM and HELLO_DET port compiled in.
REQ-028 Macro HELLO_DETECT_EN undefined: FSM and HELLO_DET port absent; all other behaviour identical.

Verification
REQ-029 STABLE_CYCLES=4, OUT_READY=1, HEX_IN 0x7F->0x06 held -> CHAR_VALID on 7th edge, CHAR_CODE=001, CHAR_ERR=0, single one-cycle valid.
REQ-030 HEX_IN toggles 0x09/0x47 every 2 cycles for 20 cycles, then 0x47 held -> exactly one accept, CHAR_CODE=010.
REQ-031 HEX_IN 0x55 held -> CHAR_CODE=111, CHAR_ERR=1.
REQ-032 OUT_READY=0, accept 0x09 then 0x40 -> CHAR_CODE stays 000, OVERFLOW=1; OUT_READY=1 -> CHAR_VALID drops next edge, OVERFLOW stays 1.
REQ-033 HELLO_DETECT_EN, sequence 0x09,0x06,0x7F,0x47,0x47,0x40 -> one HELLO_DET pulse; sequence H,E,L,L,L,O -> no pulse.
REQ-034 RESET_N low 2 cycles into stabilization of 0x40 -> all outputs 0 immediately; after release CHAR_VALID at full latency with CHAR_CODE=011.
